// File: rtl/ir_cmd_controller.sv
// ir_cmd_controller
// Takes decoded NEC IR frames and repeat codes and produces a validated
// command stream. A two-state FSM (IDLE/HELD) tracks whether a key is held.
// Repeat codes arriving while the key is held become auto-repeat commands
// once an initial skip window has passed. Commands are queued in a small
// show-ahead FIFO with a valid/ready handshake. Sticky overflow and a
// saturating reject counter are kept as status.

module ir_cmd_controller #(
    parameter logic [7:0]  ADDR         = 8'h00,
    parameter bit          ADDR_CHECK   = 1'b1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HOLD_TIMEOUT = 6_000_000,
    parameter int unsigned REPEAT_SKIP  = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        frame_valid,
    input  logic [31:0] frame_data,
    input  logic        repeat_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_data,
    output logic        cmd_repeat,
    output logic        held,
    output logic        overflow,
    output logic [7:0]  err_count,
    input  logic        clr_status
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(HOLD_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(REPEAT_SKIP + 2);

    localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_TIMEOUT - 1);
    localparam logic [SW-1:0] SKIP_LIMIT = SW'(REPEAT_SKIP);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Frame integrity: command byte must match its inverse; address is
    // optionally checked against ADDR and its own inverse.
    function automatic logic frame_ok(input logic [31:0] f);
        logic cmd_good;
        logic addr_good;
        cmd_good  = (f[23:16] == ~f[31:24]);
        addr_good = (f[7:0] == ADDR) && (f[7:0] == ~f[15:8]);
        return cmd_good && (!ADDR_CHECK || addr_good);
    endfunction

    // FSM state
    state_t          state;
    logic [7:0]      last_cmd;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   skip_cnt;

    // FIFO storage
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Event decode
    logic            good;
    logic            accept_frame;
    logic            reject_frame;
    logic            repeat_hit;
    logic            repeat_push;
    logic            push_req;
    logic [8:0]      push_entry;

    // FIFO next-state
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            ovf_set;
    logic [CW-1:0]   nxt_count;
    logic [AW-1:0]   nxt_rd;
    logic [8:0]      nxt_head;

    // Classify this cycle's input event; a frame always shadows a same-cycle repeat.
    always_comb begin
        good         = frame_ok(frame_data);
        accept_frame = frame_valid & good;
        reject_frame = frame_valid & ~good;
        repeat_hit   = ~frame_valid & repeat_valid & (state == ST_HELD);
        repeat_push  = repeat_hit & (skip_cnt >= SKIP_LIMIT);
        push_req     = accept_frame | repeat_push;
        push_entry   = accept_frame ? {1'b0, frame_data[23:16]} : {1'b1, last_cmd};
    end

    // FIFO bookkeeping: pop/push qualification and the head value after this edge.
    always_comb begin
        full    = (count == FULL_COUNT);
        do_pop  = cmd_valid & cmd_ready;
        do_push = push_req & (~full | do_pop);
        ovf_set = push_req & full & ~do_pop;

        case ({do_push, do_pop})
            2'b10:   nxt_count = count + CW'(1);
            2'b01:   nxt_count = count - CW'(1);
            default: nxt_count = count;
        endcase

        if (do_pop) begin
            nxt_rd = rd_ptr + AW'(1);
        end else begin
            nxt_rd = rd_ptr;
        end

        // The new head is the entry being written only when the queue
        // drains down to exactly that slot (empty before, or one entry popped).
        if (do_push && (nxt_rd == wr_ptr)) begin
            nxt_head = push_entry;
        end else begin
            nxt_head = mem[nxt_rd];
        end
    end

    // Key-hold FSM: tracks last command, hold timer and repeat skip window.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            last_cmd <= 8'h00;
            timer    <= {TW{1'b0}};
            skip_cnt <= {SW{1'b0}};
            held     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_frame) begin
                        last_cmd <= frame_data[23:16];
                        timer    <= {TW{1'b0}};
                        skip_cnt <= {SW{1'b0}};
                        state    <= ST_HELD;
                        held     <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        held     <= 1'b0;
                    end
                end
                ST_HELD: begin
                    if (accept_frame) begin
                        last_cmd <= frame_data[23:16];
                        timer    <= {TW{1'b0}};
                        skip_cnt <= {SW{1'b0}};
                        state    <= ST_HELD;
                        held     <= 1'b1;
                    end else if (reject_frame) begin
                        timer    <= {TW{1'b0}};
                        state    <= ST_IDLE;
                        held     <= 1'b0;
                    end else if (repeat_hit) begin
                        timer    <= {TW{1'b0}};
                        if (skip_cnt < SKIP_LIMIT) begin
                            skip_cnt <= skip_cnt + SW'(1);
                        end else begin
                            skip_cnt <= skip_cnt;
                        end
                        state    <= ST_HELD;
                        held     <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        timer    <= {TW{1'b0}};
                        state    <= ST_IDLE;
                        held     <= 1'b0;
                    end else begin
                        timer    <= timer + TW'(1);
                        state    <= ST_HELD;
                        held     <= 1'b1;
                    end
                end
                default: begin
                    timer    <= {TW{1'b0}};
                    skip_cnt <= {SW{1'b0}};
                    state    <= ST_IDLE;
                    held     <= 1'b0;
                end
            endcase
        end
    end

    // Command FIFO with registered show-ahead head outputs.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'h000;
            end
            wr_ptr     <= {AW{1'b0}};
            rd_ptr     <= {AW{1'b0}};
            count      <= {CW{1'b0}};
            cmd_valid  <= 1'b0;
            cmd_data   <= 8'h00;
            cmd_repeat <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end else begin
                wr_ptr      <= wr_ptr;
            end
            rd_ptr     <= nxt_rd;
            count      <= nxt_count;
            cmd_valid  <= (nxt_count != {CW{1'b0}});
            cmd_repeat <= nxt_head[8];
            cmd_data   <= nxt_head[7:0];
        end
    end

    // Status: sticky overflow and saturating reject counter; clear has priority.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            overflow  <= 1'b0;
            err_count <= 8'h00;
        end else if (clr_status) begin
            overflow  <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
            if (reject_frame && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule
